// File: rtl/add8_arb_sched.sv
// add8_arb_sched: round-robin scheduler sharing one 8-bit adder among NREQ requesters.
// Define ADD8_ARB_ERRMON_EN to enable the adder error monitor (err_mag/err_cnt).
module add8_arb_sched #(
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*8-1:0]   req_a,
  input  logic [NREQ*8-1:0]   req_b,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  input  logic [8:0]          add_o,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8:0]          res_sum,
  output logic [IDW-1:0]      res_id,
  output logic [1:0]          occ,
  output logic [3:0]          err_mag,
  output logic [15:0]         err_cnt
);
  logic           opv_q, opv_d, res_valid_q, res_valid_d;
  logic [7:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IDW-1:0] op_id_q, op_id_d, res_id_q, res_id_d, ptr_q, ptr_d, gnt;
  logic [8:0]     res_sum_q, res_sum_d;
  logic           found, adv_r, acc_a, hs;
  // first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = 0; k < NREQ; k++)
      if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        gnt = IDW'((int'(ptr_q) + k) % NREQ);
      end
  end
  assign adv_r = opv_q & (!res_valid_q | res_ready);
  assign acc_a = !opv_q | adv_r;
  assign hs = found & acc_a;
  assign req_ready = hs ? (NREQ'(1) << gnt) : '0;
  always_comb begin
    opv_d = hs ? 1'b1 : (adv_r ? 1'b0 : opv_q);
    op_a_d = hs ? req_a[8*gnt +: 8] : op_a_q;
    op_b_d = hs ? req_b[8*gnt +: 8] : op_b_q;
    op_id_d = hs ? gnt : op_id_q;
    ptr_d = hs ? ((gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1) : ptr_q;
    res_valid_d = adv_r ? 1'b1 : ((res_valid_q & res_ready) ? 1'b0 : res_valid_q);
    res_sum_d = adv_r ? add_o : res_sum_q;
    res_id_d = adv_r ? op_id_q : res_id_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opv_q <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_id_q <= '0;
      ptr_q <= '0;
      res_valid_q <= 1'b0;
      res_sum_q <= '0;
      res_id_q <= '0;
    end else begin
      opv_q <= opv_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      op_id_q <= op_id_d;
      ptr_q <= ptr_d;
      res_valid_q <= res_valid_d;
      res_sum_q <= res_sum_d;
      res_id_q <= res_id_d;
    end
  assign add_a = op_a_q;
  assign add_b = op_b_q;
  assign res_valid = res_valid_q;
  assign res_sum = res_sum_q;
  assign res_id = res_id_q;
  assign occ = {1'b0, opv_q} + {1'b0, res_valid_q};
`ifdef ADD8_ARB_ERRMON_EN
  logic [8:0]  exact, diff;
  logic [3:0]  err_mag_q, err_mag_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  always_comb begin
    exact = {1'b0, op_a_q} + {1'b0, op_b_q};
    diff = (add_o >= exact) ? add_o - exact : exact - add_o;
    err_mag_d = adv_r ? ((diff > 9'd15) ? 4'd15 : diff[3:0]) : err_mag_q;
    err_cnt_d = (adv_r && diff != '0 && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_mag_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_mag_q <= err_mag_d;
      err_cnt_q <= err_cnt_d;
    end
  assign err_mag = err_mag_q;
  assign err_cnt = err_cnt_q;
`else
  assign err_mag = '0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_add8_arb_sched.sv
// tb_add8_arb_sched: directed tests plus a queue-based reference model checked every cycle.
module tb_add8_arb_sched;
  localparam int NREQ = 4;
  logic            clk = 1'b0, rst_n;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [31:0]     req_a, req_b;
  logic [7:0]      add_a, add_b;
  logic [8:0]      add_o, res_sum;
  logic            res_valid, res_ready;
  logic [1:0]      res_id, occ;
  logic [3:0]      err_mag;
  logic [15:0]     err_cnt;
  bit              approx;
  int              n_chk = 0, n_fail = 0;

  add8_arb_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
    .occ(occ), .err_mag(err_mag), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // shared adder: exact, or an approximate one that undershoots sums >= 10 by 3
  function automatic int model_add(int a, int b, bit ap);
    int s;
    s = a + b;
    return (ap && s >= 10) ? s - 3 : s;
  endfunction

  always_comb add_o = 9'(model_add(int'(add_a), int'(add_b), approx));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct { int id; int sum; int err; int age; } ent_t;
  ent_t q[$];
  int   m_ptr = 0, popped_err = 0;

  // reference: in-flight ops as a FIFO; the oldest is visible once it has aged one edge
  always @(negedge clk) begin
    int g, s, e, x;
    bit any, can, ev;
    logic [NREQ-1:0] exp_rdy;
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      popped_err = 0;
    end else begin
      ev = q.size() > 0 && q[0].age >= 1;
      any = 1'b0;
      g = 0;
      for (int k = 0; k < NREQ; k++)
        if (!any && req_valid[(m_ptr + k) % NREQ]) begin
          any = 1'b1;
          g = (m_ptr + k) % NREQ;
        end
      can = q.size() < 2 || res_ready;
      exp_rdy = (any && can) ? NREQ'(1 << g) : '0;
      chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("m_res_valid", 32'(res_valid), 32'(ev));
      chk("m_occ", 32'(occ), q.size());
      if (ev) begin
        chk("m_res_sum", 32'(res_sum), q[0].sum);
        chk("m_res_id", 32'(res_id), q[0].id);
`ifdef ADD8_ARB_ERRMON_EN
        chk("m_err_mag", 32'(err_mag), q[0].err);
`endif
      end
`ifdef ADD8_ARB_ERRMON_EN
      chk("m_err_cnt", 32'(err_cnt), popped_err + ((ev && q[0].err != 0) ? 1 : 0));
`else
      chk("m_err_mag", 32'(err_mag), 0);
      chk("m_err_cnt", 32'(err_cnt), 0);
`endif
      if (ev && res_ready) begin
        if (q[0].err != 0) popped_err++;
        void'(q.pop_front());
      end
      for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
      if (any && can) begin
        x = int'(req_a[8*g +: 8]) + int'(req_b[8*g +: 8]);
        s = model_add(int'(req_a[8*g +: 8]), int'(req_b[8*g +: 8]), approx);
        e = (s > x) ? s - x : x - s;
        if (e > 15) e = 15;
        q.push_back('{g, s, e, 0});
        m_ptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    approx = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_res_sum", 32'(res_sum), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_add_a", 32'(add_a), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    step();
    // single op from requester 2
    req_a[23:16] = 8'd100;
    req_b[23:16] = 8'd27;
    req_valid = 4'b0100;
    #1 chk("single_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    #1 chk("single_occ1", 32'(occ), 1);
    chk("single_nores", 32'(res_valid), 0);
    step();
    #1 chk("single_valid", 32'(res_valid), 1);
    chk("single_sum", 32'(res_sum), 127);
    chk("single_id", 32'(res_id), 2);
    step();
    #1 chk("single_occ0", 32'(occ), 0);
    // round robin with all four requesters valid
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'(10*i + 1);
      req_b[8*i +: 8] = 8'(i);
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk("rr_id", 32'(res_id), (k - 2) % 4);
        chk("rr_sum", 32'(res_sum), 11*((k - 2) % 4) + 1);
      end
      step();
    end
    req_valid = '0;
    step();
    step();
    // backpressure with requester 1 streaming
    do_reset();
    res_ready = 1'b0;
    req_a[15:8] = 8'd30;
    req_b[15:8] = 8'd40;
    req_valid = 4'b0010;
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready[1]) begin
        hs++;
        step();
        req_a[15:8] = 8'(30 + hs);
      end else step();
    end
    chk("bp_handshakes", hs, 2);
    #1 chk("bp_occ", 32'(occ), 2);
    chk("bp_ready", 32'(req_ready), 0);
    chk("bp_sum", 32'(res_sum), 70);
    step();
    #1 chk("bp_sum_stable", 32'(res_sum), 70);
    req_valid = '0;
    res_ready = 1'b1;
    #1 chk("bp_drain0", 32'(res_sum), 70);
    step();
    #1 chk("bp_drain1_valid", 32'(res_valid), 1);
    chk("bp_drain1", 32'(res_sum), 71);
    step();
    #1 chk("bp_empty", 32'(occ), 0);
    // overflow width
    req_a[31:24] = 8'hFF;
    req_b[31:24] = 8'hFF;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();
    #1 chk("ovf_sum", 32'(res_sum), 32'h1FE);
    chk("ovf_id", 32'(res_id), 3);
    step();
    // reset mid-flight
    res_ready = 1'b0;
    req_valid = 4'hF;
    repeat (3) step();
    #1 chk("mid_occ2", 32'(occ), 2);
    rst_n = 1'b0;
    #1 chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_occ", 32'(occ), 0);
    req_valid = 4'b1010;
    step();
    rst_n = 1'b1;
    #1 chk("mid_first_grant", 32'(req_ready), 32'h2);
    res_ready = 1'b1;
    step();
    req_valid = '0;
    repeat (2) step();
    // error monitor with the approximate adder
    approx = 1'b1;
    req_a[7:0] = 8'd10;
    req_b[7:0] = 8'd20;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    #1 chk("em_sum1", 32'(res_sum), 27);
`ifdef ADD8_ARB_ERRMON_EN
    chk("em_mag1", 32'(err_mag), 3);
`else
    chk("em_mag1", 32'(err_mag), 0);
`endif
    step();
    req_a[7:0] = 8'd5;
    req_b[7:0] = 8'd0;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    #1 chk("em_sum2", 32'(res_sum), 5);
    chk("em_mag2", 32'(err_mag), 0);
`ifdef ADD8_ARB_ERRMON_EN
    chk("em_cnt", 32'(err_cnt), 1);
`else
    chk("em_cnt", 32'(err_cnt), 0);
`endif
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
